demux8_buf: RTL and testbench

DEMUX8_BUF -- requirements
Module: demux8_buf

---
 rtl/demux8_buf_if.sv | 34 +++
 rtl/demux8_buf.sv | 94 +++++++++
 tb/tb_demux8_buf.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/demux8_buf_if.sv
`default_nettype none
// ============================================================================
//  Module   : demux8_buf_if
//  Purpose  : Handshake bundle for the 1-to-8 steering buffer. It carries the
//             source side (d/select/in_valid/in_ready) and the shared
//             destination side (y/y_sel/out_valid/out_ready) plus occupancy.
//  Revision : 1.0 - initial release
// ============================================================================
interface demux8_buf_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] d;
  logic [2:0]       select;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y;
  logic [2:0]       y_sel;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;
  logic [1:0]       count;

  // Environment side: supplies words and destination readiness.
  modport master (
    output d, select, in_valid, out_ready,
    input  in_ready, y, y_sel, out_valid, count
  );

  // Buffer side: accepts words and presents the head entry.
  modport slave (
    input  d, select, in_valid, out_ready,
    output in_ready, y, y_sel, out_valid, count
  );
endinterface
`default_nettype wire

// File: rtl/demux8_buf.sv
`default_nettype none
// ============================================================================
//  Module   : demux8_buf
//  Purpose  : Two-entry FIFO of {data, destination} pairs that steers each
//             word to one of eight destinations (inverse of an 8:1 select).
//             Strict push order, head-of-line blocking, no input-to-output
//             bypass; in_ready depends on registered occupancy only.
//  Revision : 1.0 - initial release
// ============================================================================
module demux8_buf #(
  parameter int WIDTH = 32
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         flush,
  demux8_buf_if.slave       bus
);

  // Storage: two entries addressed by 1-bit pointers that wrap 1->0.
  logic [1:0][WIDTH-1:0] data_q, data_d;
  logic [1:0][2:0]       sel_q,  sel_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  // Separate occupancy keeps full (2) and empty (0) distinct when ptrs match.
  logic [1:0]            count_q, count_d;

  logic                  not_empty;
  logic                  not_full;
  logic [2:0]            head_sel;
  logic                  push;
  logic                  pop;

  assign not_empty = (count_q != 2'd0);
  assign not_full  = (count_q < 2'd2);
  assign head_sel  = sel_q[rd_ptr_q];

  // Only the head's own destination can complete a pop; other ready bits are ignored.
  assign push = bus.in_valid & not_full;
  assign pop  = not_empty & bus.out_ready[head_sel];

  // Next-state: flush empties the buffer and overrides any same-edge push/pop.
  always_comb begin
    data_d   = data_q;
    sel_d    = sel_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = bus.d;
        sel_d[wr_ptr_q]  = bus.select;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset clears everything and wins over flush/push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      sel_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      data_q   <= data_d;
      sel_q    <= sel_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Outputs come from registered state only; zeros while empty.
  assign bus.in_ready  = not_full;
  assign bus.count     = count_q;
  assign bus.y         = not_empty ? data_q[rd_ptr_q] : '0;
  assign bus.y_sel     = not_empty ? head_sel : 3'd0;
  assign bus.out_valid = not_empty ? (8'h01 << head_sel) : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_demux8_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux8_buf
//  Purpose  : Self-checking bench for demux8_buf with a FIFO scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux8_buf;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  sel;
  } ent_t;

  logic clk;
  logic reset;
  logic flush;
  int   n_vec;
  int   n_err;
  int   n_pop;
  ent_t sb[$];

  demux8_buf_if #(.WIDTH(32)) bus ();

  demux8_buf #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Compare outputs against the model, then advance one edge and update the model.
  task automatic step();
    ent_t        h;
    logic        push;
    logic        pop;
    logic [31:0] y_seen;
    chk("count", 64'(bus.count), 64'(sb.size()));
    chk("in_ready", 64'(bus.in_ready), 64'(sb.size() < 2));
    if (sb.size() > 0) begin
      h = sb[0];
      chk("out_valid", 64'(bus.out_valid), 64'(8'h01 << h.sel));
      chk("y", 64'(bus.y), 64'(h.data));
      chk("y_sel", 64'(bus.y_sel), 64'(h.sel));
    end else begin
      chk("out_valid_idle", 64'(bus.out_valid), 64'h0);
      chk("y_idle", 64'(bus.y), 64'h0);
      chk("y_sel_idle", 64'(bus.y_sel), 64'h0);
    end
    chk("onehot0", 64'($onehot0(bus.out_valid)), 64'h1);
    push   = bus.in_valid && (sb.size() < 2);
    pop    = (sb.size() > 0) && bus.out_ready[sb[0].sel];
    y_seen = bus.y;
    h      = '{data: bus.d, sel: bus.select};
    @(posedge clk);
    #1;
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (pop) begin
        ent_t e;
        e = sb.pop_front();
        n_pop++;
        chk("deliver", 64'(y_seen), 64'(e.data));
      end
      if (push) sb.push_back(h);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_pop = 0;
    reset = 1'b1; flush = 1'b0;
    bus.in_valid  = 1'b1;
    bus.d         = 32'h1234_5678;
    bus.select    = 3'd3;
    bus.out_ready = 8'h00;

    // Reset held two cycles with in_valid high.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(bus.count), 64'h0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
    chk("rst_y", 64'(bus.y), 64'h0);
    reset = 1'b0;
    step();                                   // first push right after deassert
    chk("first_push", 64'(bus.count), 64'h1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 8'hFF;
    step();
    chk("drained", 64'(bus.count), 64'h0);

    // Single transfer.
    bus.d = 32'hDEADBEEF; bus.select = 3'd5; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("single_ov", 64'(bus.out_valid), 64'h20);
    chk("single_y", 64'(bus.y), 64'hDEADBEEF);
    chk("single_ysel", 64'(bus.y_sel), 64'h5);
    step();
    chk("single_cnt", 64'(bus.count), 64'h0);

    // Fill and stall with head-of-line blocking.
    bus.out_ready = 8'h00;
    bus.in_valid = 1'b1; bus.d = 32'h11; bus.select = 3'd1; step();
    bus.d = 32'h66; bus.select = 3'd6; step();
    bus.d = 32'h77; bus.select = 3'd3;
    chk("full_in_ready", 64'(bus.in_ready), 64'h0);
    chk("full_ov", 64'(bus.out_valid), 64'h02);
    step();                                   // third push refused
    chk("full_cnt", 64'(bus.count), 64'h2);
    bus.in_valid = 1'b0;
    bus.out_ready = 8'h40;
    step(); step();
    chk("hol_ov", 64'(bus.out_valid), 64'h02);
    chk("hol_y", 64'(bus.y), 64'h11);
    bus.out_ready = 8'h02;
    step();
    chk("second_ov", 64'(bus.out_valid), 64'h40);
    chk("second_y", 64'(bus.y), 64'h66);
    bus.out_ready = 8'hFF;
    step();
    chk("fill_drained", 64'(bus.count), 64'h0);

    // Streaming: one push and one pop per cycle.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.d = 32'hA000_0000 + 32'(i);
      bus.select = 3'(i % 8);
      if (i > 0) chk("stream_ov", 64'(bus.out_valid), 64'(8'h01 << ((i - 1) % 8)));
      step();
    end
    bus.in_valid = 1'b0;
    step();

    // Flush with a concurrent push attempt, then the same with reset.
    for (int k = 0; k < 2; k++) begin
      bus.out_ready = 8'h00;
      bus.in_valid = 1'b1; bus.d = 32'hC0; bus.select = 3'd2; step();
      bus.d = 32'hC1; bus.select = 3'd4; step();
      chk("pre_clear_cnt", 64'(bus.count), 64'h2);
      if (k == 0) flush = 1'b1; else reset = 1'b1;
      bus.d = 32'hC2; bus.select = 3'd7;
      step();
      flush = 1'b0; reset = 1'b0; bus.in_valid = 1'b0;
      chk("clear_cnt", 64'(bus.count), 64'h0);
      chk("clear_ov", 64'(bus.out_valid), 64'h0);
      bus.out_ready = 8'hFF;
      step(); step();
    end

    // Random traffic against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.select    = 3'($urandom_range(0, 7));
      bus.d         = $urandom;
      bus.out_ready = 8'($urandom_range(0, 255));
      flush         = ($urandom_range(0, 99) == 0);
      step();
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 8'hFF;
    step(); step(); step();
    chk("end_empty", 64'(bus.count), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
